// File: rtl/dispatch_steer_pkg.sv
// Shared dispatch definitions: instruction classes, payload layout, FSM states
// and the capacity helpers used by the steering logic.
package dispatch_steer_pkg;

   localparam int PW = 83;

   typedef enum logic [1:0] {
      IQ_ALU = 2'd0,
      IQ_JMP = 2'd1,
      IQ_LSQ = 2'd2,
      IQ_ILL = 2'd3
   } iq_class_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_PAIR  = 2'd1,
      ST_ONE   = 2'd2
   } disp_state_t;

   // Field order matches the rename stage packing, MSB first.
   typedef struct packed {
      logic [5:0]  pos;
      logic [5:0]  prd;
      logic [5:0]  prs1;
      logic        prs1_valid;
      logic [5:0]  prs2;
      logic        prs2_valid;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
   } disp_payload_t;

   // Free slots a queue can take this cycle: 0, 1 or 2.
   function automatic logic [1:0] iq_capacity(input logic no_free, input logic one_free);
      logic [1:0] cap;
      if (no_free) begin
         cap = 2'd0;
      end else if (one_free) begin
         cap = 2'd1;
      end else begin
         cap = 2'd2;
      end
      return cap;
   endfunction

   // Capacity seen by an instruction of a given class; illegal never fits.
   function automatic logic [1:0] class_capacity(input iq_class_t  cls,
                                                 input logic [1:0] cap_alu,
                                                 input logic [1:0] cap_jmp,
                                                 input logic [1:0] cap_lsq);
      logic [1:0] cap;
      case (cls)
         IQ_ALU:  cap = cap_alu;
         IQ_JMP:  cap = cap_jmp;
         IQ_LSQ:  cap = cap_lsq;
         IQ_ILL:  cap = 2'd0;
         default: cap = 2'd0;
      endcase
      return cap;
   endfunction

endpackage

// File: rtl/dispatch_steer_port_pack.sv
// Maps the two held entries and their leave flags onto the two dispatch
// ports of one issue queue. Older entry always owns port 1.
module iq_port_pack #(
   parameter int                             PW     = dispatch_steer_pkg::PW,
   parameter dispatch_steer_pkg::iq_class_t  QCLASS = dispatch_steer_pkg::IQ_ALU
) (
   input  logic                          h1_leave,
   input  dispatch_steer_pkg::iq_class_t h1_class,
   input  logic [PW-1:0]                 h1_payload,
   input  logic                          h2_leave,
   input  dispatch_steer_pkg::iq_class_t h2_class,
   input  logic [PW-1:0]                 h2_payload,
   output logic                          valid1,
   output logic [PW-1:0]                 payload1,
   output logic                          valid2,
   output logic [PW-1:0]                 payload2
);

   logic sel1_s;
   logic sel2_s;

   // Which held entries are leaving toward this queue in the current cycle.
   always_comb begin
      sel1_s = h1_leave && (h1_class == QCLASS);
      sel2_s = h2_leave && (h2_class == QCLASS);
   end

   // Lone entry goes to port 1; a same-queue pair fills port 1 then port 2.
   always_comb begin
      valid1   = 1'b0;
      payload1 = '0;
      valid2   = 1'b0;
      payload2 = '0;
      if (sel1_s) begin
         valid1   = 1'b1;
         payload1 = h1_payload;
         if (sel2_s) begin
            valid2   = 1'b1;
            payload2 = h2_payload;
         end else begin
            valid2   = 1'b0;
            payload2 = '0;
         end
      end else if (sel2_s) begin
         valid1   = 1'b1;
         payload1 = h2_payload;
      end else begin
         valid1   = 1'b0;
         payload1 = '0;
      end
   end

endmodule

// File: rtl/dispatch_steer.sv
// Two-entry in-order dispatch buffer steering renamed instructions onto the
// ALU, JMP and LSQ issue queue ports according to their free capacity.
module dispatch_steer #(
   parameter int PW = dispatch_steer_pkg::PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid1,
   input  logic          in_valid2,
   input  logic [1:0]    in_class1,
   input  logic [1:0]    in_class2,
   input  logic [PW-1:0] in_payload1,
   input  logic [PW-1:0] in_payload2,
   output logic          in_ready,
   input  logic          flush,
   input  logic          no_free_iq_alu,
   input  logic          one_free_iq_alu,
   input  logic          no_free_iq_jmp,
   input  logic          one_free_iq_jmp,
   input  logic          no_free_iq_lsq,
   input  logic          one_free_iq_lsq,
   output logic          ins_valid1_alu,
   output logic          ins_valid2_alu,
   output logic [PW-1:0] payload1_alu,
   output logic [PW-1:0] payload2_alu,
   output logic          ins_valid1_jmp,
   output logic          ins_valid2_jmp,
   output logic [PW-1:0] payload1_jmp,
   output logic [PW-1:0] payload2_jmp,
   output logic          ins_valid1_lsq,
   output logic          ins_valid2_lsq,
   output logic [PW-1:0] payload1_lsq,
   output logic [PW-1:0] payload2_lsq,
   output logic [15:0]   stall_cnt
);

   import dispatch_steer_pkg::*;

   disp_state_t   state_r;
   disp_state_t   state_s;
   iq_class_t     h1_class_r;
   iq_class_t     h2_class_r;
   iq_class_t     h1_class_s;
   iq_class_t     h2_class_s;
   logic [PW-1:0] h1_payload_r;
   logic [PW-1:0] h2_payload_r;
   logic [PW-1:0] h1_payload_s;
   logic [PW-1:0] h2_payload_s;
   logic [15:0]   stall_cnt_r;

   logic [1:0]    cap_alu_s;
   logic [1:0]    cap_jmp_s;
   logic [1:0]    cap_lsq_s;
   logic [1:0]    h1_cap_s;
   logic [1:0]    h2_cap_s;
   logic          h1_leave_s;
   logic          h2_leave_s;
   logic          all_leave_s;
   logic          ready_s;
   logic          accept_s;
   logic          stall_s;

   // Per-queue capacity and the capacity each held entry is competing for.
   always_comb begin
      cap_alu_s = iq_capacity(no_free_iq_alu, one_free_iq_alu);
      cap_jmp_s = iq_capacity(no_free_iq_jmp, one_free_iq_jmp);
      cap_lsq_s = iq_capacity(no_free_iq_lsq, one_free_iq_lsq);
      h1_cap_s  = class_capacity(h1_class_r, cap_alu_s, cap_jmp_s, cap_lsq_s);
      h2_cap_s  = class_capacity(h2_class_r, cap_alu_s, cap_jmp_s, cap_lsq_s);
   end

   // In-order leave decision: H2 can only follow H1, and a same-queue pair
   // needs two free slots.
   always_comb begin
      h1_leave_s = 1'b0;
      h2_leave_s = 1'b0;
      if (flush) begin
         h1_leave_s = 1'b0;
         h2_leave_s = 1'b0;
      end else begin
         case (state_r)
            ST_PAIR: begin
               h1_leave_s = (h1_cap_s != 2'd0);
               if (h1_class_r == h2_class_r) begin
                  h2_leave_s = h1_leave_s && (h2_cap_s == 2'd2);
               end else begin
                  h2_leave_s = h1_leave_s && (h2_cap_s != 2'd0);
               end
            end
            ST_ONE: begin
               h2_leave_s = (h2_cap_s != 2'd0);
            end
            default: begin
               h1_leave_s = 1'b0;
               h2_leave_s = 1'b0;
            end
         endcase
      end
   end

   // Buffer drains this cycle, which lets a new pair in without a bubble.
   always_comb begin
      case (state_r)
         ST_PAIR: all_leave_s = h1_leave_s && h2_leave_s;
         ST_ONE:  all_leave_s = h2_leave_s;
         default: all_leave_s = 1'b1;
      endcase
   end

   // Ready, accept and stall qualification.
   always_comb begin
      if (reset || flush) begin
         ready_s = 1'b0;
      end else if (state_r == ST_EMPTY) begin
         ready_s = 1'b1;
      end else begin
         ready_s = all_leave_s;
      end
      accept_s = ready_s && (in_valid1 || in_valid2);
      if ((state_r != ST_EMPTY) && !flush) begin
         stall_s = !all_leave_s;
      end else begin
         stall_s = 1'b0;
      end
   end

   // Next-state and buffer load; a single accepted instruction always sits in H2.
   always_comb begin
      state_s      = state_r;
      h1_class_s   = h1_class_r;
      h2_class_s   = h2_class_r;
      h1_payload_s = h1_payload_r;
      h2_payload_s = h2_payload_r;
      if (flush) begin
         state_s = ST_EMPTY;
      end else if (accept_s) begin
         if (in_valid1 && in_valid2) begin
            state_s      = ST_PAIR;
            h1_class_s   = iq_class_t'(in_class1);
            h1_payload_s = in_payload1;
            h2_class_s   = iq_class_t'(in_class2);
            h2_payload_s = in_payload2;
         end else if (in_valid1) begin
            state_s      = ST_ONE;
            h2_class_s   = iq_class_t'(in_class1);
            h2_payload_s = in_payload1;
         end else begin
            state_s      = ST_ONE;
            h2_class_s   = iq_class_t'(in_class2);
            h2_payload_s = in_payload2;
         end
      end else begin
         case (state_r)
            ST_PAIR: begin
               if (h1_leave_s && h2_leave_s) begin
                  state_s = ST_EMPTY;
               end else if (h1_leave_s) begin
                  state_s = ST_ONE;
               end else begin
                  state_s = ST_PAIR;
               end
            end
            ST_ONE: begin
               if (h2_leave_s) begin
                  state_s = ST_EMPTY;
               end else begin
                  state_s = ST_ONE;
               end
            end
            default: state_s = ST_EMPTY;
         endcase
      end
   end

   // State and held-entry registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_EMPTY;
         h1_class_r   <= IQ_ALU;
         h2_class_r   <= IQ_ALU;
         h1_payload_r <= '0;
         h2_payload_r <= '0;
      end else begin
         state_r      <= state_s;
         h1_class_r   <= h1_class_s;
         h2_class_r   <= h2_class_s;
         h1_payload_r <= h1_payload_s;
         h2_payload_r <= h2_payload_s;
      end
   end

   // Saturating count of cycles where held work could not fully drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= 16'd0;
      end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign in_ready  = ready_s;
   assign stall_cnt = stall_cnt_r;

   iq_port_pack #(.PW(PW), .QCLASS(IQ_ALU)) u_pack_alu (
      .h1_leave   (h1_leave_s),
      .h1_class   (h1_class_r),
      .h1_payload (h1_payload_r),
      .h2_leave   (h2_leave_s),
      .h2_class   (h2_class_r),
      .h2_payload (h2_payload_r),
      .valid1     (ins_valid1_alu),
      .payload1   (payload1_alu),
      .valid2     (ins_valid2_alu),
      .payload2   (payload2_alu)
   );

   iq_port_pack #(.PW(PW), .QCLASS(IQ_JMP)) u_pack_jmp (
      .h1_leave   (h1_leave_s),
      .h1_class   (h1_class_r),
      .h1_payload (h1_payload_r),
      .h2_leave   (h2_leave_s),
      .h2_class   (h2_class_r),
      .h2_payload (h2_payload_r),
      .valid1     (ins_valid1_jmp),
      .payload1   (payload1_jmp),
      .valid2     (ins_valid2_jmp),
      .payload2   (payload2_jmp)
   );

   iq_port_pack #(.PW(PW), .QCLASS(IQ_LSQ)) u_pack_lsq (
      .h1_leave   (h1_leave_s),
      .h1_class   (h1_class_r),
      .h1_payload (h1_payload_r),
      .h2_leave   (h2_leave_s),
      .h2_class   (h2_class_r),
      .h2_payload (h2_payload_r),
      .valid1     (ins_valid1_lsq),
      .payload1   (payload1_lsq),
      .valid2     (ins_valid2_lsq),
      .payload2   (payload2_lsq)
   );

endmodule

// File: tb/tb_dispatch_steer.sv
// Scenario bench for dispatch_steer: per-cycle expected observations are
// queued as stimulus is built and popped when the DUT outputs are sampled.
module tb_dispatch_steer;

   localparam int W = 83;
   localparam logic [1:0] C_ALU = 2'd0;
   localparam logic [1:0] C_JMP = 2'd1;
   localparam logic [1:0] C_LSQ = 2'd2;
   localparam logic [1:0] C_ILL = 2'd3;
   localparam int A1 = 0;
   localparam int A2 = 1;
   localparam int J1 = 2;
   localparam int L1 = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid1, in_valid2;
   logic [1:0]    in_class1, in_class2;
   logic [W-1:0]  in_payload1, in_payload2;
   logic          in_ready;
   logic          flush;
   logic          no_free_iq_alu, one_free_iq_alu;
   logic          no_free_iq_jmp, one_free_iq_jmp;
   logic          no_free_iq_lsq, one_free_iq_lsq;
   logic          ins_valid1_alu, ins_valid2_alu;
   logic          ins_valid1_jmp, ins_valid2_jmp;
   logic          ins_valid1_lsq, ins_valid2_lsq;
   logic [W-1:0]  payload1_alu, payload2_alu;
   logic [W-1:0]  payload1_jmp, payload2_jmp;
   logic [W-1:0]  payload1_lsq, payload2_lsq;
   logic [15:0]   stall_cnt;

   typedef struct packed {
      logic [5:0]     vld;
      logic [6*W-1:0] pl;
      logic           rdy;
      logic [15:0]    stall;
   } obs_t;

   typedef struct packed {
      logic         v1;
      logic [1:0]   c1;
      logic [W-1:0] p1;
      logic         v2;
      logic [1:0]   c2;
      logic [W-1:0] p2;
      logic [2:0]   nf;
      logic [2:0]   of;
      logic         fl;
   } stim_t;

   obs_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   dispatch_steer #(.PW(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid1(in_valid1), .in_valid2(in_valid2),
      .in_class1(in_class1), .in_class2(in_class2),
      .in_payload1(in_payload1), .in_payload2(in_payload2),
      .in_ready(in_ready), .flush(flush),
      .no_free_iq_alu(no_free_iq_alu), .one_free_iq_alu(one_free_iq_alu),
      .no_free_iq_jmp(no_free_iq_jmp), .one_free_iq_jmp(one_free_iq_jmp),
      .no_free_iq_lsq(no_free_iq_lsq), .one_free_iq_lsq(one_free_iq_lsq),
      .ins_valid1_alu(ins_valid1_alu), .ins_valid2_alu(ins_valid2_alu),
      .payload1_alu(payload1_alu), .payload2_alu(payload2_alu),
      .ins_valid1_jmp(ins_valid1_jmp), .ins_valid2_jmp(ins_valid2_jmp),
      .payload1_jmp(payload1_jmp), .payload2_jmp(payload2_jmp),
      .ins_valid1_lsq(ins_valid1_lsq), .ins_valid2_lsq(ins_valid2_lsq),
      .payload1_lsq(payload1_lsq), .payload2_lsq(payload2_lsq),
      .stall_cnt(stall_cnt)
   );

   function automatic obs_t mk(input logic rdy, input logic [15:0] st);
      obs_t o;
      o       = '0;
      o.rdy   = rdy;
      o.stall = st;
      return o;
   endfunction

   function automatic obs_t put(input obs_t o, input int s, input logic [W-1:0] p);
      obs_t r;
      r             = o;
      r.vld[s]      = 1'b1;
      r.pl[s*W +: W] = p;
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.vld   = {ins_valid2_lsq, ins_valid1_lsq, ins_valid2_jmp, ins_valid1_jmp,
                 ins_valid2_alu, ins_valid1_alu};
      o.pl    = {payload2_lsq, payload1_lsq, payload2_jmp, payload1_jmp,
                 payload2_alu, payload1_alu};
      o.rdy   = in_ready;
      o.stall = stall_cnt;
      return o;
   endfunction

   function automatic stim_t sv(input logic v1, input logic [1:0] c1, input logic [W-1:0] p1,
                                input logic v2, input logic [1:0] c2, input logic [W-1:0] p2,
                                input logic [2:0] nf, input logic [2:0] of, input logic fl);
      stim_t s;
      s.v1 = v1; s.c1 = c1; s.p1 = p1;
      s.v2 = v2; s.c2 = c2; s.p2 = p2;
      s.nf = nf; s.of = of; s.fl = fl;
      return s;
   endfunction

   function automatic stim_t idle(input logic [2:0] nf, input logic [2:0] of, input logic fl);
      return sv(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, nf, of, fl);
   endfunction

   function automatic logic [W-1:0] rnd_pl();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[W-1:0] | {{(W-1){1'b0}}, 1'b1};
   endfunction

   task automatic apply(input stim_t s);
      in_valid1 = s.v1; in_class1 = s.c1; in_payload1 = s.p1;
      in_valid2 = s.v2; in_class2 = s.c2; in_payload2 = s.p2;
      no_free_iq_alu = s.nf[0]; no_free_iq_jmp = s.nf[1]; no_free_iq_lsq = s.nf[2];
      one_free_iq_alu = s.of[0]; one_free_iq_jmp = s.of[1]; one_free_iq_lsq = s.of[2];
      flush = s.fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      apply(idle(3'b000, 3'b000, 1'b0));
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      obs_t act, ex;
      reset = 1'b1;
      apply(sv(1'b1, C_ALU, rnd_pl(), 1'b1, C_JMP, rnd_pl(), 3'b000, 3'b000, 1'b0));
      step();
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            reset = 1'b0;
            apply(idle(3'b000, 3'b000, 1'b0));
            sb.push_back(mk(1'b1, 16'd0));
         end else begin
            sb.push_back(mk(1'b0, 16'd0));
         end
         #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL reset c%0d: got vld=%b rdy=%b stall=%0d, want vld=%b rdy=%b stall=%0d",
                     k, act.vld, act.rdy, act.stall, ex.vld, ex.rdy, ex.stall);
         end
         step();
      end
   endtask

   task automatic test_alu_jmp();
      stim_t st[$]; obs_t act, ex;
      logic [W-1:0] p1, p2;
      p1 = rnd_pl(); p2 = rnd_pl();
      do_reset();
      st.push_back(sv(1'b1, C_ALU, p1, 1'b1, C_JMP, p2, 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(put(put(mk(1'b1, 16'd0), A1, p1), J1, p2));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      foreach (st[i]) begin
         apply(st[i]); #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL alu_jmp c%0d: got vld=%b rdy=%b stall=%0d pl=%h want vld=%b rdy=%b stall=%0d pl=%h",
                     i, act.vld, act.rdy, act.stall, act.pl, ex.vld, ex.rdy, ex.stall, ex.pl);
         end
         step();
      end
   endtask

   task automatic test_same_queue();
      stim_t st[$]; obs_t act, ex;
      logic [W-1:0] p1, p2;
      p1 = rnd_pl(); p2 = rnd_pl();
      do_reset();
      st.push_back(sv(1'b1, C_ALU, p1, 1'b1, C_ALU, p2, 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      st.push_back(idle(3'b000, 3'b001, 1'b0)); sb.push_back(put(mk(1'b0, 16'd0), A1, p1));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(put(mk(1'b1, 16'd1), A1, p2));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd1));
      foreach (st[i]) begin
         apply(st[i]); #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL same_queue c%0d: got vld=%b rdy=%b stall=%0d pl=%h want vld=%b rdy=%b stall=%0d pl=%h",
                     i, act.vld, act.rdy, act.stall, act.pl, ex.vld, ex.rdy, ex.stall, ex.pl);
         end
         step();
      end
   endtask

   task automatic test_lsq_blocked();
      stim_t st[$]; obs_t act, ex;
      logic [W-1:0] p1, p2;
      p1 = rnd_pl(); p2 = rnd_pl();
      do_reset();
      st.push_back(sv(1'b1, C_LSQ, p1, 1'b1, C_JMP, p2, 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      for (int k = 0; k < 3; k++) begin
         st.push_back(idle(3'b100, 3'b000, 1'b0)); sb.push_back(mk(1'b0, 16'(k)));
      end
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(put(put(mk(1'b1, 16'd3), L1, p1), J1, p2));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd3));
      foreach (st[i]) begin
         apply(st[i]); #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL lsq_blocked c%0d: got vld=%b rdy=%b stall=%0d pl=%h want vld=%b rdy=%b stall=%0d pl=%h",
                     i, act.vld, act.rdy, act.stall, act.pl, ex.vld, ex.rdy, ex.stall, ex.pl);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$]; obs_t act, ex;
      logic [W-1:0] p [1:8];
      for (int k = 1; k <= 8; k++) p[k] = rnd_pl();
      do_reset();
      st.push_back(sv(1'b1, C_ALU, p[1], 1'b1, C_ALU, p[2], 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      st.push_back(sv(1'b1, C_LSQ, p[3], 1'b1, C_JMP, p[4], 3'b000, 3'b110, 1'b0));
      sb.push_back(put(put(mk(1'b1, 16'd0), A1, p[1]), A2, p[2]));
      st.push_back(sv(1'b0, C_JMP, '0, 1'b1, C_ALU, p[5], 3'b000, 3'b110, 1'b0));
      sb.push_back(put(put(mk(1'b1, 16'd0), L1, p[3]), J1, p[4]));
      st.push_back(sv(1'b1, C_JMP, p[6], 1'b0, C_ALU, '0, 3'b000, 3'b000, 1'b0)); sb.push_back(put(mk(1'b1, 16'd0), A1, p[5]));
      st.push_back(idle(3'b010, 3'b000, 1'b0)); sb.push_back(mk(1'b0, 16'd0));
      st.push_back(sv(1'b1, C_JMP, p[7], 1'b1, C_LSQ, p[8], 3'b000, 3'b000, 1'b0)); sb.push_back(put(mk(1'b1, 16'd1), J1, p[6]));
      st.push_back(idle(3'b100, 3'b000, 1'b0)); sb.push_back(put(mk(1'b0, 16'd1), J1, p[7]));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(put(mk(1'b1, 16'd2), L1, p[8]));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd2));
      foreach (st[i]) begin
         apply(st[i]); #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL back_to_back c%0d: got vld=%b rdy=%b stall=%0d pl=%h want vld=%b rdy=%b stall=%0d pl=%h",
                     i, act.vld, act.rdy, act.stall, act.pl, ex.vld, ex.rdy, ex.stall, ex.pl);
         end
         step();
      end
   endtask

   task automatic test_flush();
      stim_t st[$]; obs_t act, ex;
      do_reset();
      st.push_back(sv(1'b1, C_ALU, rnd_pl(), 1'b1, C_LSQ, rnd_pl(), 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      st.push_back(sv(1'b1, C_ALU, rnd_pl(), 1'b1, C_ALU, rnd_pl(), 3'b000, 3'b000, 1'b1)); sb.push_back(mk(1'b0, 16'd0));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      foreach (st[i]) begin
         apply(st[i]); #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL flush c%0d: got vld=%b rdy=%b stall=%0d, want vld=%b rdy=%b stall=%0d",
                     i, act.vld, act.rdy, act.stall, ex.vld, ex.rdy, ex.stall);
         end
         step();
      end
   endtask

   task automatic test_illegal();
      stim_t st[$]; obs_t act, ex;
      logic [W-1:0] p2;
      p2 = rnd_pl();
      do_reset();
      st.push_back(sv(1'b1, C_ILL, rnd_pl(), 1'b0, C_ALU, '0, 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd0));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b0, 16'd0));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b0, 16'd1));
      st.push_back(idle(3'b000, 3'b000, 1'b1)); sb.push_back(mk(1'b0, 16'd2));
      st.push_back(sv(1'b1, C_ALU, p2, 1'b1, C_ILL, rnd_pl(), 3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd2));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(put(mk(1'b0, 16'd2), A1, p2));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b0, 16'd3));
      st.push_back(idle(3'b000, 3'b000, 1'b1)); sb.push_back(mk(1'b0, 16'd4));
      st.push_back(idle(3'b000, 3'b000, 1'b0)); sb.push_back(mk(1'b1, 16'd4));
      foreach (st[i]) begin
         apply(st[i]); #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL illegal c%0d: got vld=%b rdy=%b stall=%0d pl=%h want vld=%b rdy=%b stall=%0d pl=%h",
                     i, act.vld, act.rdy, act.stall, act.pl, ex.vld, ex.rdy, ex.stall, ex.pl);
         end
         step();
      end
   endtask

   task automatic test_saturate();
      obs_t act, ex;
      do_reset();
      apply(sv(1'b1, C_ILL, rnd_pl(), 1'b0, C_ALU, '0, 3'b000, 3'b000, 1'b0));
      step();
      apply(idle(3'b000, 3'b000, 1'b0));
      repeat (65534) step();
      for (int k = 0; k < 2; k++) begin
         sb.push_back(mk(1'b0, (k == 0) ? 16'hFFFE : 16'hFFFF));
         #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL saturate c%0d: got vld=%b rdy=%b stall=%h, want vld=%b rdy=%b stall=%h",
                     k, act.vld, act.rdy, act.stall, ex.vld, ex.rdy, ex.stall);
         end
         repeat (4400) step();
      end
   endtask

   task automatic test_async_reset();
      obs_t act, ex;
      do_reset();
      apply(sv(1'b1, C_LSQ, rnd_pl(), 1'b1, C_JMP, rnd_pl(), 3'b000, 3'b000, 1'b0));
      step();
      apply(idle(3'b100, 3'b000, 1'b0));
      step();
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin
            #2;
            reset = 1'b1;
            sb.push_back(mk(1'b0, 16'd0));
         end else if (k == 1) begin
            apply(idle(3'b000, 3'b000, 1'b0));
            step();
            reset = 1'b0;
            sb.push_back(mk(1'b1, 16'd0));
         end else begin
            step();
            sb.push_back(mk(1'b1, 16'd0));
         end
         #1;
         act = sample(); ex = sb.pop_front(); n_cmp++;
         if (act !== ex) begin
            n_err++;
            $display("FAIL async_reset c%0d: got vld=%b rdy=%b stall=%0d, want vld=%b rdy=%b stall=%0d",
                     k, act.vld, act.rdy, act.stall, ex.vld, ex.rdy, ex.stall);
         end
      end
      step();
   endtask

   initial begin
      reset = 1'b1;
      apply(idle(3'b000, 3'b000, 1'b0));
      @(posedge clk);
      #1;
      test_reset();
      test_alu_jmp();
      test_same_queue();
      test_lsq_blocked();
      test_back_to_back();
      test_flush();
      test_illegal();
      test_saturate();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dispatch_steer.md
DISPATCH_STEER -- requirements
Module: dispatch_steer

Interface
REQ-001 SHALL have parameter PW, default 83, meaning the width of one dispatch payload (disp_payload_t from the package).
REQ-002 SHALL have the port `clk`: input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have the port `reset`: input, 1 bit, asynchronous and active-high.
REQ-004 SHALL have the ports `in_valid1` and `in_valid2`: input, 1 bit each, meaning the rename slot 1 and slot 2 instructions are valid; slot 1 is older.
REQ-005 SHALL have the ports `in_class1` and `in_class2`: input, 2 bits each, encoded 0 = ALU, 1 = JMP, 2 = LSQ, 3 = illegal.
REQ-006 SHALL have the ports `in_payload1` and `in_payload2`: input, PW bits each. Each payload is {pos, prd, prs1, prs1_valid, prs2, prs2_valid, funct3, funct7, rs1, rs2, rd, pc}.
REQ-007 SHALL have the port `in_ready`: output, 1 bit; the input pair is accepted on an edge where in_ready is high and at least one in_valid is high.
REQ-008 SHALL have the port `flush`: input, 1 bit, meaning discard all held instructions.
REQ-009 SHALL have, for each X in {alu, jmp, lsq}, the ports `no_free_iq_X` and `one_free_iq_X`: input, 1 bit each, giving that issue queue's free-slot status.
REQ-010 SHALL have, for each X, the ports `ins_valid1_X` and `ins_valid2_X`: output, 1 bit each, the dispatch port valids of that queue.
REQ-011 SHALL have, for each X, the ports `payload1_X` and `payload2_X`: output, PW bits each, the dispatch port payloads of that queue.
REQ-012 SHALL have the port `stall_cnt`: output, 16 bits, counting cycles in which held instructions could not all be dispatched.

Function
REQ-013 SHALL hold instructions in a two-entry buffer (H1 older, H2 younger) controlled by the FSM states EMPTY, PAIR and ONE.
- PAIR: H1 and H2 both held.
- ONE: a single held instruction, always kept in H2.
REQ-014 SHALL compute the capacity of queue X each cycle as: 0 if no_free_iq_X is high; else 1 if one_free_iq_X is high; else 2.
REQ-015 SHALL dispatch strictly in program order: H2 may leave only if H1 leaves in the same cycle or has already left.
REQ-016 SHALL require that, when both held entries target the same queue, that queue's capacity is 2 for both to leave; if capacity is 1, only H1 leaves.
REQ-017 SHALL place a lone instruction for a queue on port 1, and when two instructions go to the same queue, place the older on port 1 and the younger on port 2.
REQ-018 SHALL drive every ins_valid*_X and payload*_X output combinationally from the buffer contents and the capacities; payloads are 0 whenever the matching valid is low.
REQ-019 SHALL drive in_ready high when the state is EMPTY, or when every held entry dispatches in the current cycle (registered-to-combinational ready, no bubble).
REQ-020 SHALL give a minimum latency of one cycle: a pair accepted at edge N appears on the issue queue ports in the cycle after edge N.
REQ-021 SHALL make these FSM transitions on an edge with an accept:
- to PAIR if both in_valid are high;
- to ONE if exactly one is high (that instruction goes into H2).
REQ-022 SHALL make these FSM transitions on an edge without an accept:
- PAIR with H1 only leaving -> ONE, with H2 kept;
- all held entries leaving -> EMPTY;
- nothing leaving -> the state is unchanged.
REQ-023 SHALL, when in_class is 3, accept the instruction but never dispatch it, treating it as a stall until flush; stall_cnt increments each such cycle.
REQ-024 SHALL, while flush is high, force all ins_valid outputs and in_ready low.
REQ-025 SHALL, on the edge where flush is high, go to EMPTY regardless of the other inputs.
REQ-026 SHALL increment stall_cnt in each cycle where the state is not EMPTY, flush is low, and at least one held entry fails to dispatch; stall_cnt saturates at 16'hFFFF.

Reset
REQ-027 SHALL, while reset is high, asynchronously force the state to EMPTY, H1 and H2 to 0, and stall_cnt to 0.
REQ-028 SHALL, while reset is high, hold all ins_valid outputs low, all payloads at 0, and in_ready low.
REQ-029 SHALL drive in_ready high in the first cycle after reset is released.
REQ-030 SHALL, if reset is asserted mid-stall, drop the held instructions without any dispatch.

Structure
REQ-031 SHALL place the following in a shared package, used by all issue queues:
- the iq_class_t enum (ALU/JMP/LSQ/ILL);
- the disp_payload_t packed struct;
- the constant PW = 83.
REQ-032 SHALL use one sub-module, iq_port_pack, instantiated once per queue, which maps held entries and their leave flags onto port 1 and port 2.

Verification
REQ-033 SHALL be covered by this scenario: pair of (ALU, JMP) with all queues empty -> in the next cycle ins_valid1_alu = 1 and ins_valid1_jmp = 1, state is EMPTY, stall_cnt = 0.
REQ-034 SHALL be covered by this scenario: pair of (ALU, ALU) with one_free_iq_alu = 1 -> H1 is on payload1_alu and H2 is held; in the next cycle with capacity 2, H2 appears on port 1; stall_cnt = 1.
REQ-035 SHALL be covered by this scenario: pair of (LSQ, JMP) with no_free_iq_lsq = 1 for 3 cycles -> no valid outputs and in_ready = 0 for 3 cycles; both dispatch together on the 4th cycle; stall_cnt = 3.
REQ-036 SHALL be covered by this scenario: held PAIR plus flush pulsed for 1 cycle -> no valid outputs during the flush cycle; the state is EMPTY after that edge.
REQ-037 SHALL be covered by this scenario: 70000 forced stall cycles -> stall_cnt holds at 16'hFFFF.
REQ-038 SHALL be covered by this scenario: reset asserted asynchronously mid-stall (between edges) -> all outputs are 0 immediately, and in_ready = 1 one cycle after release.
